// File: rtl/tx_frame_serializer_if.sv
// Handshake and serial-line bundle for tx_frame_serializer.
// master = byte source side, slave = serializer side.
interface tx_frame_serializer_if #(
  parameter int N = 8
);
  logic         start;
  logic [N-1:0] din;
  logic         ready;
  logic         busy;
  logic         dout;
  logic         done;

  modport master (output start, output din,
                  input  ready, input busy, input dout, input done);
  modport slave  (input  start, input din,
                  output ready, output busy, output dout, output done);
endinterface

// File: rtl/tx_frame_serializer.sv
// Frame serializer: high preamble, N data bits LSB first, then return to idle low.
// Optional even-parity bit after the data when TX_PARITY_EN is defined.
module tx_frame_serializer #(
  parameter int N               = 8,
  parameter int BIT_CYCLES      = 20,
  parameter int PREAMBLE_CYCLES = 10
) (
  input  logic                 clk,
  input  logic                 rst,
  tx_frame_serializer_if.slave bus
);
  localparam int MAXC = (BIT_CYCLES > PREAMBLE_CYCLES) ? BIT_CYCLES : PREAMBLE_CYCLES;
  localparam int CW   = $clog2(MAXC + 1);
  localparam int BW   = $clog2(N + 2);

  typedef enum logic [1:0] {
    S_IDLE,
    S_PRE,
    S_DATA
`ifdef TX_PARITY_EN
    , S_PAR
`endif
  } state_t;

  state_t         state_q;
  logic [N-1:0]   shreg_q;
  logic [CW-1:0]  cyc_q;
  logic [BW-1:0]  bit_q;
  logic           dout_q;
  logic           ready_q;
  logic           busy_q;
  logic           done_q;
`ifdef TX_PARITY_EN
  logic           par_q;
`endif

  logic [N-1:0]   shreg_d;
  logic           pre_last;
  logic           bit_period_last;
  logic           bit_last;

  assign shreg_d         = shreg_q >> 1;
  assign pre_last        = (cyc_q == CW'(PREAMBLE_CYCLES - 1));
  assign bit_period_last = (cyc_q == CW'(BIT_CYCLES - 1));
  assign bit_last        = (bit_q == BW'(N - 1));

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= S_IDLE;
      shreg_q <= '0;
      cyc_q   <= '0;
      bit_q   <= '0;
      dout_q  <= 1'b0;
      ready_q <= 1'b1;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
`ifdef TX_PARITY_EN
      par_q   <= 1'b0;
`endif
    end else begin
      done_q <= 1'b0;
      case (state_q)
        S_IDLE: begin
          if (bus.start && ready_q) begin
            shreg_q <= bus.din;
            cyc_q   <= '0;
            bit_q   <= '0;
            state_q <= S_PRE;
            dout_q  <= 1'b1;
            ready_q <= 1'b0;
            busy_q  <= 1'b1;
`ifdef TX_PARITY_EN
            par_q   <= ^bus.din;
`endif
          end
        end
        S_PRE: begin
          if (pre_last) begin
            state_q <= S_DATA;
            cyc_q   <= '0;
            dout_q  <= shreg_q[0];
          end else begin
            cyc_q <= cyc_q + CW'(1);
          end
        end
        S_DATA: begin
          if (bit_period_last) begin
            cyc_q   <= '0;
            shreg_q <= shreg_d;
            bit_q   <= bit_q + BW'(1);
            if (bit_last) begin
`ifdef TX_PARITY_EN
              state_q <= S_PAR;
              dout_q  <= par_q;
`else
              // Frame complete: this edge makes the done/IDLE-entry cycle.
              state_q <= S_IDLE;
              dout_q  <= 1'b0;
              ready_q <= 1'b1;
              busy_q  <= 1'b0;
              done_q  <= 1'b1;
`endif
            end else begin
              dout_q <= shreg_d[0];
            end
          end else begin
            cyc_q <= cyc_q + CW'(1);
          end
        end
`ifdef TX_PARITY_EN
        S_PAR: begin
          if (bit_period_last) begin
            cyc_q   <= '0;
            state_q <= S_IDLE;
            dout_q  <= 1'b0;
            ready_q <= 1'b1;
            busy_q  <= 1'b0;
            done_q  <= 1'b1;
          end else begin
            cyc_q <= cyc_q + CW'(1);
          end
        end
`endif
        default: state_q <= S_IDLE;
      endcase
    end
  end

  assign bus.ready = ready_q;
  assign bus.busy  = busy_q;
  assign bus.dout  = dout_q;
  assign bus.done  = done_q;
endmodule

// File: tb/tb_tx_frame_serializer.sv
// Scoreboard bench: stimulus appends each accepted frame's expected per-cycle
// waveform to a queue; the monitor pops one entry per cycle and compares.
module tb_tx_frame_serializer;
  localparam int N  = 8;
  localparam int BC = 20;
  localparam int PC = 10;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  tx_frame_serializer_if #(.N(N)) bus ();

  tx_frame_serializer #(
    .N(N), .BIT_CYCLES(BC), .PREAMBLE_CYCLES(PC)
  ) dut (
    .clk(clk),
    .rst(rst),
    .bus(bus)
  );

  // Each entry: {ready, busy, dout, done} for one future cycle.
  logic [3:0] exp_q[$];
  int  checks = 0;
  int  passed = 0;
  int  cyc_no = 0;
  int  frames = 0;
  bit  mon_en = 1'b0;
  bit  acc_flag = 1'b0;

  function automatic void push_frame(input logic [N-1:0] w);
    for (int p = 0; p < PC; p++) exp_q.push_back(4'b0110);
    for (int i = 0; i < N; i++)
      for (int b = 0; b < BC; b++) exp_q.push_back({1'b0, 1'b1, w[i], 1'b0});
`ifdef TX_PARITY_EN
    for (int b = 0; b < BC; b++) exp_q.push_back({1'b0, 1'b1, ^w, 1'b0});
`endif
    exp_q.push_back(4'b1001);
    frames++;
    $display("frame %0d accepted at cycle %0d din=%h", frames, cyc_no, w);
  endfunction

  // Monitor: one comparison per cycle, sampled 1 time unit after the edge.
  initial begin
    logic [3:0] e;
    logic [3:0] got;
    forever begin
      @(posedge clk);
      #1;
      cyc_no++;
      if (mon_en) begin
        if (exp_q.size() != 0) e = exp_q.pop_front();
        else                   e = 4'b1000;
        got = {bus.ready, bus.busy, bus.dout, bus.done};
        checks++;
        if (got === e) passed++;
        else $display("FAIL outputs cycle %0d {ready,busy,dout,done} got %b expected %b",
                      cyc_no, got, e);
      end
    end
  end

  task automatic cyc(input logic s, input logic [N-1:0] d);
    @(negedge clk);
    bus.start = s;
    bus.din   = d;
    acc_flag  = 1'b0;
    // Ready in the current cycle exactly when no expected activity is pending.
    if (s && !rst && exp_q.size() == 0) begin
      push_frame(d);
      acc_flag = 1'b1;
    end
  endtask

  task automatic send(input logic [N-1:0] d);
    for (int i = 0; i < 1000; i++) begin
      cyc(1'b1, d);
      if (acc_flag) break;
    end
  endtask

  task automatic do_reset();
    @(negedge clk);
    rst       = 1'b1;
    bus.start = 1'b0;
    exp_q.delete();
    $display("reset asserted at cycle %0d", cyc_no);
    @(negedge clk);
    rst = 1'b0;
  endtask

  task automatic drain();
    for (int i = 0; i < 2000 && exp_q.size() != 0; i++) cyc(1'b0, N'($urandom));
    cyc(1'b0, '0);
  endtask

  initial begin
    bus.start = 1'b0;
    bus.din   = '0;
    repeat (2) @(negedge clk);
    mon_en = 1'b1;
    rst    = 1'b0;

    repeat (50) cyc(1'b0, '0);

    // Back-to-back frames with start held through the done cycles.
    send(8'hA5);
    send(8'hFF);
    send(8'h00);
    cyc(1'b0, '0);
    drain();

    // Start pulse while busy is ignored.
    send(8'h5A);
    repeat (49) cyc(1'b0, N'($urandom));
    cyc(1'b1, 8'h3C);
    drain();

    // Reset in the middle of a frame, then a fresh frame.
    send(8'hC3);
    repeat (58) cyc(1'b0, N'($urandom));
    do_reset();
    send(8'h01);
    cyc(1'b0, '0);
    drain();

    // Random start pulses, random din churn and rare resets.
    for (int i = 0; i < 3000; i++) begin
      if ($urandom_range(0, 999) == 0) do_reset();
      else cyc($urandom_range(0, 3) == 0, N'($urandom));
    end
    drain();

    checks++;
    if (exp_q.size() == 0) passed++;
    else $display("FAIL drain pending entries got %0d expected 0", exp_q.size());

    $display("%0d/%0d checks passed", passed, checks);
    $finish;
  end
endmodule
